icache_req_arb: RTL and testbench
=================================

// Module: icache_req_arb
// PURPOSE
//  Shares the single icache tag-pipeline request slot among three requesters:
//  downstream snoop, upstream demand fetch and the prefetcher.
//  Fixed priority snoop > demand > prefetch, with two anti-starvation rules:
//  a snoop-streak limit protects demand/prefetch, and prefetch aging protects prefetch.
//  The winner is registered into a full-throughput output stage feeding the pipeline.
// PARAMETERS
//  SNP_BURST_MAX  4  max consecutive snoop grants while another source waits (>=1)
//  PREF_AGE_MAX   8  lost arbitrations before a waiting prefetch outranks demand (>=1)
// PORTS
//  clk                   in   1         clock
//  rst_n                 in   1         async active-low reset
//  prefetch_enable       in   1         0: prefetch source masked
//  upstream_rxreq_vld    in   1         demand fetch valid
//  upstream_rxreq_rdy    out  1         demand fetch accepted
//  upstream_rxreq_pld    in   pc_req_t  demand payload
//  downstream_rxsnp_vld  in   1         snoop valid
//  downstream_rxsnp_rdy  out  1         snoop accepted
//  downstream_rxsnp_pld  in   pc_req_t  snoop payload
//  prefetch_req_vld      in   1         prefetch valid
//  prefetch_req_rdy      out  1         prefetch accepted
//  prefetch_req_pld      in   pc_req_t  prefetch payload
//  arb_req_vld           out  1         registered request to tag pipeline
//  arb_req_rdy           in   1         tag pipeline accepts
//  arb_req_pld           out  pc_req_t  registered winning payload
//  arb_req_src           out  2         winner source: 0 demand, 1 prefetch, 2 snoop
// BEHAVIOUR
//  - Reset (async): arb_req_vld=0, arb_req_pld=0, arb_req_src=0, snp_streak=0, pref_age=0.
//    An in-flight request is dropped; requesters reissue.
//  - load_en = !arb_req_vld | arb_req_rdy. Arbitration happens only when load_en=1.
//    When load_en=0, every *_rdy is 0, the output is held stable, and counters freeze.
//  - pf_v = prefetch_req_vld & prefetch_enable. other_v = demand_v | pf_v.
//  - Winner order, first match wins:
//    1. snoop, if snp_vld & !(snp_streak==SNP_BURST_MAX & other_v)
//    2. prefetch, if pf_v & pref_age==PREF_AGE_MAX
//    3. demand, if demand_v
//    4. prefetch, if pf_v
//    5. snoop, if the limit blocked it and nothing above matched (cannot occur)
//  - Only the winner's rdy is 1, combinational within the same cycle. rdy may depend
//    on vld, so requesters must not derive vld from rdy.
//  - On load_en: arb_req_vld<=any grant; on a grant, pld and src load from the winner.
//    Latency is 1 cycle from accept to arb_req_vld. Back-to-back throughput is 1 req/clk.
//  - snp_streak (clog2(SNP_BURST_MAX+1) bits), updated on load_en only:
//    - snoop grant with other_v: +1, saturating
//    - snoop grant with !other_v: 0
//    - non-snoop grant: 0
//  - pref_age (clog2(PREF_AGE_MAX+1) bits), updated on load_en only:
//    - pf_v and another source granted: +1, saturating
//    - prefetch grant, !pf_v, or prefetch_enable=0: 0
//  - prefetch_enable=0: prefetch_req_rdy=0 and pref_age held at 0. A prefetch already
//    in the output register still completes.
//  - Same-cycle vld on all three sources: only one is granted; losers hold vld and pld.
// TESTING
//  1. Demand only, arb_req_rdy=1, pld=A:
//     upstream_rxreq_rdy=1 in cycle N; arb_req_vld=1, pld=A, src=0 in N+1.
//  2. Snoop+demand held valid:
//     grants S,S,S,S,D repeating; snp_streak peaks at 4, then returns to 0.
//  3. Demand+prefetch held valid, no snoop:
//     grants D x8 then P, repeating; pref_age peaks at 8.
//  4. Output full, arb_req_rdy=0 for 5 cycles:
//     all input rdy=0; arb_req_pld/src stable; counters unchanged; resumes on rdy=1.
//  5. prefetch_enable=0 with prefetch_req_vld=1 for 20 cycles:
//     prefetch_req_rdy=0, pref_age=0; after re-enable with no demand, grant next cycle.
//  6. rst_n low mid-stream with arb_req_vld=1:
//     arb_req_vld=0 immediately; after release, the first grant follows base priority.

Source files
------------

// File: rtl/icache_req_arb.sv
// Three-way request arbiter for the icache tag-pipeline slot: snoop > demand > prefetch,
// with a snoop-streak limit and prefetch aging, feeding a registered full-throughput output stage.
module icache_req_arb #(
    parameter int PLD_W         = 32,
    parameter int SNP_BURST_MAX = 4,
    parameter int PREF_AGE_MAX  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 prefetch_enable,
    input  logic                                 upstream_rxreq_vld,
    output logic                                 upstream_rxreq_rdy,
    input  logic [PLD_W-1:0]                     upstream_rxreq_pld,
    input  logic                                 downstream_rxsnp_vld,
    output logic                                 downstream_rxsnp_rdy,
    input  logic [PLD_W-1:0]                     downstream_rxsnp_pld,
    input  logic                                 prefetch_req_vld,
    output logic                                 prefetch_req_rdy,
    input  logic [PLD_W-1:0]                     prefetch_req_pld,
    output logic                                 arb_req_vld,
    input  logic                                 arb_req_rdy,
    output logic [PLD_W-1:0]                     arb_req_pld,
    output logic [1:0]                           arb_req_src,
    output logic [$clog2(SNP_BURST_MAX+1)-1:0]   dbg_snp_streak,
    output logic [$clog2(PREF_AGE_MAX+1)-1:0]    dbg_pref_age
);

    // Handshake: every channel transfers on a rising edge where vld & rdy are both 1.
    // Input rdy is combinational and depends on vld; arb_req_vld never depends on arb_req_rdy.

    localparam int SW = $clog2(SNP_BURST_MAX + 1);
    localparam int AW = $clog2(PREF_AGE_MAX + 1);
    localparam logic [SW-1:0] SNP_MAX_C = SW'(SNP_BURST_MAX);
    localparam logic [AW-1:0] AGE_MAX_C = AW'(PREF_AGE_MAX);

    localparam logic [1:0] SRC_DEMAND   = 2'd0;
    localparam logic [1:0] SRC_PREFETCH = 2'd1;
    localparam logic [1:0] SRC_SNOOP    = 2'd2;

    logic              r_vld;
    logic [PLD_W-1:0]  r_pld;
    logic [1:0]        r_src;
    logic [SW-1:0]     r_snp_streak;
    logic [AW-1:0]     r_pref_age;

    logic              w_load_en;
    logic              w_pf_v;
    logic              w_other_v;
    logic              w_snp_blocked;
    logic              w_pf_aged;
    logic              w_gnt_snp;
    logic              w_gnt_dem;
    logic              w_gnt_pf;
    logic              w_any_gnt;
    logic [PLD_W-1:0]  w_win_pld;
    logic [1:0]        w_win_src;
    logic [SW-1:0]     w_snp_streak_nxt;
    logic [AW-1:0]     w_pref_age_nxt;

    assign w_load_en     = !r_vld || arb_req_rdy;
    assign w_pf_v        = prefetch_req_vld && prefetch_enable;
    assign w_other_v     = upstream_rxreq_vld || w_pf_v;
    assign w_snp_blocked = (r_snp_streak == SNP_MAX_C) && w_other_v;
    assign w_pf_aged     = (r_pref_age == AGE_MAX_C);

    always_comb begin
        w_gnt_snp = 1'b0;
        w_gnt_dem = 1'b0;
        w_gnt_pf  = 1'b0;
        if (w_load_en) begin
            if (downstream_rxsnp_vld && !w_snp_blocked) begin
                w_gnt_snp = 1'b1;
            end else if (w_pf_v && w_pf_aged) begin
                w_gnt_pf = 1'b1;
            end else if (upstream_rxreq_vld) begin
                w_gnt_dem = 1'b1;
            end else if (w_pf_v) begin
                w_gnt_pf = 1'b1;
            end else if (downstream_rxsnp_vld) begin
                // Limit only bites while another source waits, so this is a safety net.
                w_gnt_snp = 1'b1;
            end
        end
    end

    assign w_any_gnt = w_gnt_snp || w_gnt_dem || w_gnt_pf;

    always_comb begin
        w_win_pld = upstream_rxreq_pld;
        w_win_src = SRC_DEMAND;
        if (w_gnt_snp) begin
            w_win_pld = downstream_rxsnp_pld;
            w_win_src = SRC_SNOOP;
        end else if (w_gnt_pf) begin
            w_win_pld = prefetch_req_pld;
            w_win_src = SRC_PREFETCH;
        end
    end

    assign downstream_rxsnp_rdy = w_gnt_snp;
    assign upstream_rxreq_rdy   = w_gnt_dem;
    assign prefetch_req_rdy     = w_gnt_pf;

    always_comb begin
        w_snp_streak_nxt = r_snp_streak;
        if (w_load_en) begin
            if (w_gnt_snp && w_other_v) begin
                w_snp_streak_nxt = (r_snp_streak == SNP_MAX_C) ? r_snp_streak
                                                                : r_snp_streak + SW'(1);
            end else begin
                w_snp_streak_nxt = '0;
            end
        end
    end

    always_comb begin
        w_pref_age_nxt = r_pref_age;
        if (w_load_en) begin
            if (!w_pf_v || w_gnt_pf) begin
                w_pref_age_nxt = '0;
            end else if (w_any_gnt) begin
                w_pref_age_nxt = w_pf_aged ? r_pref_age : r_pref_age + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld        <= 1'b0;
            r_pld        <= '0;
            r_src        <= SRC_DEMAND;
            r_snp_streak <= '0;
            r_pref_age   <= '0;
        end else begin
            r_snp_streak <= w_snp_streak_nxt;
            r_pref_age   <= w_pref_age_nxt;
            if (w_load_en) begin
                r_vld <= w_any_gnt;
                if (w_any_gnt) begin
                    r_pld <= w_win_pld;
                    r_src <= w_win_src;
                end
            end
        end
    end

    assign arb_req_vld    = r_vld;
    assign arb_req_pld    = r_pld;
    assign arb_req_src    = r_src;
    assign dbg_snp_streak = r_snp_streak;
    assign dbg_pref_age   = r_pref_age;

endmodule

// File: tb/tb_icache_req_arb.sv
// Directed bench for icache_req_arb: a cycle model of the arbitration rules is compared
// against the DUT every cycle, with literal expectations pinning the key sequences.
module tb_icache_req_arb;

    localparam int PLD_W = 32;
    localparam logic [31:0] A_PLD = 32'h0000_00A1;
    localparam logic [31:0] D_PLD = 32'hD000_0001;
    localparam logic [31:0] S_PLD = 32'h5000_0002;
    localparam logic [31:0] P_PLD = 32'hF000_0003;

    logic             clk;
    logic             rst_n;
    logic             prefetch_enable;
    logic             upstream_rxreq_vld;
    logic             upstream_rxreq_rdy;
    logic [PLD_W-1:0] upstream_rxreq_pld;
    logic             downstream_rxsnp_vld;
    logic             downstream_rxsnp_rdy;
    logic [PLD_W-1:0] downstream_rxsnp_pld;
    logic             prefetch_req_vld;
    logic             prefetch_req_rdy;
    logic [PLD_W-1:0] prefetch_req_pld;
    logic             arb_req_vld;
    logic             arb_req_rdy;
    logic [PLD_W-1:0] arb_req_pld;
    logic [1:0]       arb_req_src;
    logic [2:0]       dbg_snp_streak;
    logic [3:0]       dbg_pref_age;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b1;

    icache_req_arb #(.PLD_W(PLD_W), .SNP_BURST_MAX(4), .PREF_AGE_MAX(8)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .prefetch_enable      (prefetch_enable),
        .upstream_rxreq_vld   (upstream_rxreq_vld),
        .upstream_rxreq_rdy   (upstream_rxreq_rdy),
        .upstream_rxreq_pld   (upstream_rxreq_pld),
        .downstream_rxsnp_vld (downstream_rxsnp_vld),
        .downstream_rxsnp_rdy (downstream_rxsnp_rdy),
        .downstream_rxsnp_pld (downstream_rxsnp_pld),
        .prefetch_req_vld     (prefetch_req_vld),
        .prefetch_req_rdy     (prefetch_req_rdy),
        .prefetch_req_pld     (prefetch_req_pld),
        .arb_req_vld          (arb_req_vld),
        .arb_req_rdy          (arb_req_rdy),
        .arb_req_pld          (arb_req_pld),
        .arb_req_src          (arb_req_src),
        .dbg_snp_streak       (dbg_snp_streak),
        .dbg_pref_age         (dbg_pref_age)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the output register contents plus the two counters as plain integers.
    // Winner codes: -1 none, 0 demand, 1 prefetch, 2 snoop.
    bit          m_vld;
    logic [31:0] m_pld;
    int          m_src;
    int          m_streak;
    int          m_age;

    function automatic int pick(input bit snp, input bit dem, input bit pf,
                                input int streak, input int age, input bit load);
        bit others;
        others = dem || pf;
        if (!load) return -1;
        if (snp && !(streak == 4 && others)) return 2;
        if (pf && age == 8) return 1;
        if (dem) return 0;
        if (pf) return 1;
        if (snp) return 2;
        return -1;
    endfunction

    always @(negedge clk) begin
        bit load, pf, others;
        int w;
        if (!rst_n) begin
            m_vld = 1'b0; m_pld = '0; m_src = 0; m_streak = 0; m_age = 0;
            if (cmp_en) begin
                chk("rst_vld", 32'(arb_req_vld), 32'd0);
                chk("rst_pld", arb_req_pld, 32'd0);
                chk("rst_src", 32'(arb_req_src), 32'd0);
                chk("rst_streak", 32'(dbg_snp_streak), 32'd0);
                chk("rst_age", 32'(dbg_pref_age), 32'd0);
            end
        end else if (cmp_en) begin
            load   = !m_vld || arb_req_rdy;
            pf     = prefetch_req_vld && prefetch_enable;
            others = upstream_rxreq_vld || pf;
            w = pick(downstream_rxsnp_vld, upstream_rxreq_vld, pf, m_streak, m_age, load);
            chk("cmp_dem_rdy", 32'(upstream_rxreq_rdy), 32'(w == 0));
            chk("cmp_pf_rdy", 32'(prefetch_req_rdy), 32'(w == 1));
            chk("cmp_snp_rdy", 32'(downstream_rxsnp_rdy), 32'(w == 2));
            chk("cmp_out_vld", 32'(arb_req_vld), 32'(m_vld));
            chk("cmp_out_pld", arb_req_pld, m_pld);
            chk("cmp_out_src", 32'(arb_req_src), 32'(m_src));
            chk("cmp_streak", 32'(dbg_snp_streak), 32'(m_streak));
            chk("cmp_age", 32'(dbg_pref_age), 32'(m_age));
            if (load) begin
                m_vld = (w >= 0);
                if (w == 0) begin m_pld = upstream_rxreq_pld;   m_src = 0; end
                if (w == 1) begin m_pld = prefetch_req_pld;     m_src = 1; end
                if (w == 2) begin m_pld = downstream_rxsnp_pld; m_src = 2; end
                m_streak = (w == 2 && others) ? ((m_streak < 4) ? m_streak + 1 : 4) : 0;
                if (!pf || w == 1) m_age = 0;
                else if (w >= 0)   m_age = (m_age < 8) ? m_age + 1 : 8;
            end
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input bit s, input bit d, input bit p);
        downstream_rxsnp_vld = s;
        upstream_rxreq_vld   = d;
        prefetch_req_vld     = p;
    endtask

    initial begin
        rst_n = 1'b0;
        prefetch_enable = 1'b1;
        arb_req_rdy = 1'b1;
        set_src(0, 0, 0);
        upstream_rxreq_pld   = A_PLD;
        downstream_rxsnp_pld = S_PLD;
        prefetch_req_pld     = P_PLD;
        repeat (3) cyc();
        rst_n = 1'b1;

        // demand only: accept in N, visible in N+1
        cyc();
        set_src(0, 1, 0);
        @(negedge clk);
        chk("t1_dem_rdy", 32'(upstream_rxreq_rdy), 32'd1);
        cyc();
        set_src(0, 0, 0);
        @(negedge clk);
        chk("t1_vld", 32'(arb_req_vld), 32'd1);
        chk("t1_pld", arb_req_pld, A_PLD);
        chk("t1_src", 32'(arb_req_src), 32'd0);
        cyc();

        // snoop + demand: S,S,S,S,D repeating
        upstream_rxreq_pld = D_PLD;
        set_src(1, 1, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t2_snp_rdy", 32'(downstream_rxsnp_rdy), 32'((k % 5) != 4));
            chk("t2_dem_rdy", 32'(upstream_rxreq_rdy), 32'((k % 5) == 4));
            chk("t2_streak", 32'(dbg_snp_streak), 32'(k % 5));
            cyc();
        end
        set_src(0, 0, 0);
        repeat (2) cyc();

        // demand + prefetch: D x8 then P
        set_src(0, 1, 1);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk("t3_pf_rdy", 32'(prefetch_req_rdy), 32'((k % 9) == 8));
            chk("t3_dem_rdy", 32'(upstream_rxreq_rdy), 32'((k % 9) != 8));
            chk("t3_age", 32'(dbg_pref_age), 32'(k % 9));
            cyc();
        end
        repeat (3) cyc();

        // output stalled for 5 cycles with demand holding D, age frozen at 3
        arb_req_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_dem_rdy", 32'(upstream_rxreq_rdy), 32'd0);
            chk("t4_pf_rdy", 32'(prefetch_req_rdy), 32'd0);
            chk("t4_snp_rdy", 32'(downstream_rxsnp_rdy), 32'd0);
            chk("t4_pld", arb_req_pld, D_PLD);
            chk("t4_src", 32'(arb_req_src), 32'd0);
            chk("t4_age", 32'(dbg_pref_age), 32'd3);
            cyc();
        end
        arb_req_rdy = 1'b1;
        @(negedge clk);
        chk("t4_resume", 32'(upstream_rxreq_rdy), 32'd1);
        cyc();
        set_src(0, 0, 0);
        repeat (2) cyc();

        // prefetch masked for 20 cycles, then granted right after re-enable
        prefetch_enable = 1'b0;
        set_src(0, 0, 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("t5_pf_rdy", 32'(prefetch_req_rdy), 32'd0);
            chk("t5_age", 32'(dbg_pref_age), 32'd0);
            cyc();
        end
        prefetch_enable = 1'b1;
        @(negedge clk);
        chk("t5_pf_rdy_en", 32'(prefetch_req_rdy), 32'd1);
        cyc();
        @(negedge clk);
        chk("t5_src", 32'(arb_req_src), 32'd1);
        chk("t5_pld", arb_req_pld, P_PLD);

        // reset mid-stream
        cyc();
        set_src(1, 1, 1);
        cyc();
        @(negedge clk);
        chk("t6_vld_pre", 32'(arb_req_vld), 32'd1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t6_vld_rst", 32'(arb_req_vld), 32'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_snp_rdy", 32'(downstream_rxsnp_rdy), 32'd1);
        chk("t6_dem_rdy", 32'(upstream_rxreq_rdy), 32'd0);
        cyc();
        @(negedge clk);
        chk("t6_src", 32'(arb_req_src), 32'd2);
        chk("t6_pld", arb_req_pld, S_PLD);
        cyc();
        set_src(0, 0, 0);
        repeat (3) cyc();

        // final report
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
